bitpack_stream_ctrl: RTL and testbench
======================================

Name: bitpack_stream_ctrl

Overview:
- Controls the 256-bit MSB-first bit-packing accumulator that sits behind the Huffman encoder.
- Accepts variable-length codes of 0..32 bits through a valid/ready handshake and appends each one at the accumulator LSB side.
- Emits fixed-width, left-aligned output words toward the memory writer, with backpressure on both sides.
- On end of stream it drains the residue, zero-pads the final word and tags it last.

Parameters:
- ACC_W, 256, accumulator width in bits; must be >= OUT_W+32.
- OUT_W, 64, output word width; legal values 32, 64, 128.
- LEN_W, $clog2(ACC_W)+1, width of the internal fill counter acc_len.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  code present.
- in_ready  output  1  code accepted when in_valid && in_ready.
- in_code  input  32  code value, right-aligned; bits at or above in_len are masked internally.
- in_len  input  6  code length, 0..32; values >32 are illegal, and the bench asserts on them.
- in_last  input  1  final code of the stream.
- out_valid  output  1  word present.
- out_ready  input  1  word consumed when out_valid && out_ready.
- out_data  output  OUT_W  left-aligned packed bits; unused LSBs are zero.
- out_bits  output  8  count of valid bits in out_data, 0..OUT_W.
- out_last  output  1  final word of the stream.
- total_bits  output  32  bits accepted in the current stream; cleared when the final word is consumed.

Behaviour:
- Reset (synchronous, clk edge while reset=1):
  - acc_len=0, state=ACCUM, total_bits=0, accumulator contents don't-care.
  - While reset is high: out_valid=0, in_ready=0, out_last=0, out_bits=0, out_data=0.
- Accumulator update on accept: acc <= (acc << in_len) | masked in_code. This is MSB-first: the oldest bit sits at position acc_len-1.
- Word extraction: out_data = acc[acc_len-1 -: OUT_W] when acc_len >= OUT_W. Otherwise it is the acc_len valid bits shifted to the MSB end, with zero fill below.
- Output signals are combinational from registered state only (no input-to-output paths). They stay stable while out_valid && !out_ready.
- States:
  - ACCUM:
    - in_ready = (acc_len <= ACC_W-32).
    - out_valid = (acc_len >= OUT_W), with out_bits=OUT_W and out_last=0.
    - Accepting a code with in_last=1 moves the block to FLUSH next cycle.
  - FLUSH:
    - in_ready=0 and out_valid=1.
    - out_bits = min(acc_len, OUT_W).
    - out_last = (acc_len <= OUT_W).
    - When the last word is consumed: go to ACCUM, acc_len=0, total_bits=0.
- Simultaneous accept and emit in the same cycle:
  - The emitted word is taken from the pre-update accumulator.
  - acc_len_next = acc_len + in_len - OUT_W.
  - No bubble is inserted.
- Latency: a code accepted at cycle t can appear in out_data at t+1.
- Zero-length codes:
  - in_len=0 is a legal no-op append.
  - in_len=0 with in_last=1 still triggers FLUSH.
- Empty flush: entering FLUSH with acc_len=0 emits one terminator word with out_bits=0, out_data=0, out_last=1.
- Bit counter: total_bits increments by in_len on every accept and wraps modulo 2^32.
- Overflow: the in_ready rule guarantees acc_len never exceeds ACC_W, with or without backpressure.
- Reset mid-stream or mid-FLUSH:
  - Takes effect at the next edge.
  - The residue is discarded and no last word is emitted.

Test Plan:
- Reset: hold reset for 3 cycles -> in_ready=0 and out_valid=0 during reset; in_ready=1, out_valid=0, total_bits=0 on the first cycle after release.
- Byte packing: 8 codes of len 8, values 0x01..0x08, out_ready=1 -> one word 0x0102030405060708, out_bits=64, out_last=0, emitted the cycle after the 8th accept.
- Backpressure: out_ready=0, stream 32-bit codes 0xA0000000+i -> 8 accepts, then in_ready=0 at acc_len=256; out_data holds 0xA0000000A0000001 stable. Release out_ready -> words continue in order, no loss.
- Partial flush: code 3'b101 (len 3), then code 0xF (len 4, in_last=1) -> single word 0xBE00000000000000, out_bits=7, out_last=1; afterwards state=ACCUM and total_bits=0.
- Exact flush and terminator:
  - 8 len-8 codes with in_last on the 8th -> one word with out_bits=64 and out_last=1.
  - A lone len-0 code with in_last=1 -> one word with out_bits=0, out_data=0, out_last=1.
- Simultaneous accept/emit plus mid-flush reset:
  - With acc_len=64 and out_ready=1, accept a len-20 code -> acc_len=20 next cycle.
  - Assert reset during FLUSH -> out_valid=0 next cycle and no out_last word is seen.

Source files
------------

// File: rtl/bitpack_stream_if.sv
// Code-in / word-out stream bundle for the bit-packing controller.
// The slave side is the packer; the master side is the encoder plus memory writer.
interface bitpack_stream_if #(
  parameter int unsigned OUT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_code;
  logic [5:0]       in_len;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [7:0]       out_bits;
  logic             out_last;
  logic [31:0]      total_bits;

  modport slave (
    input  in_valid, in_code, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bits, out_last, total_bits
  );

  modport master (
    output in_valid, in_code, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bits, out_last, total_bits
  );
endinterface

// File: rtl/bitpack_stream_ctrl.sv
// MSB-first bit packer: appends 0..32-bit codes into an ACC_W accumulator and
// emits left-aligned OUT_W words; end of stream drains and zero-pads the residue.
module bitpack_stream_ctrl #(
  parameter int unsigned ACC_W = 256,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned LEN_W = $clog2(ACC_W) + 1
) (
  input logic              clk,
  input logic              reset,
  bitpack_stream_if.slave  bus
);

  typedef enum logic {StAccum, StFlush} state_e;

  localparam logic [LEN_W-1:0] LenOut   = LEN_W'(OUT_W);
  localparam logic [LEN_W-1:0] LenInMax = LEN_W'(ACC_W - 32);
  localparam logic [LEN_W-1:0] LenAcc   = LEN_W'(ACC_W);

  state_e           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [31:0]      r_total, w_total_next;

  logic [LEN_W-1:0] w_shamt;
  logic [ACC_W-1:0] w_window;
  logic [LEN_W-1:0] w_flush_bits;
  logic [31:0]      w_mask;
  logic [31:0]      w_code;
  logic             w_in_ready, w_out_valid, w_out_last;
  logic             w_accept, w_emit;

  // Shifting the valid bits to the top drops stale history above r_len and zero-fills below.
  assign w_shamt      = LenAcc - r_len;
  assign w_window     = r_acc << w_shamt;
  assign w_flush_bits = (r_len < LenOut) ? r_len : LenOut;
  // A shift by 32 yields zero, so the subtraction gives an all-ones mask for full-width codes.
  assign w_mask       = (32'h1 << bus.in_len) - 32'h1;
  assign w_code       = bus.in_code & w_mask;

  always_comb begin : p_out
    w_in_ready    = 1'b0;
    w_out_valid   = 1'b0;
    w_out_last    = 1'b0;
    bus.out_bits  = 8'd0;
    bus.out_data  = '0;
    if (!reset) begin
      unique case (r_state)
        StAccum: begin
          w_in_ready   = (r_len <= LenInMax);
          w_out_valid  = (r_len >= LenOut);
          bus.out_bits = 8'(OUT_W);
          bus.out_data = OUT_W'(w_window >> (ACC_W - OUT_W));
        end
        StFlush: begin
          w_out_valid  = 1'b1;
          w_out_last   = (r_len <= LenOut);
          bus.out_bits = 8'(w_flush_bits);
          bus.out_data = OUT_W'(w_window >> (ACC_W - OUT_W));
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_last   = w_out_last;
  assign bus.total_bits = r_total;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_emit   = w_out_valid && bus.out_ready;

  always_comb begin : p_next
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_len_next   = r_len;
    w_total_next = r_total;
    // The outgoing word is read from the pre-update accumulator, so both can happen at once.
    if (w_accept) begin
      w_acc_next   = (r_acc << bus.in_len) | ACC_W'(w_code);
      w_len_next   = r_len + LEN_W'(bus.in_len);
      w_total_next = r_total + 32'(bus.in_len);
    end
    if (w_emit) begin
      w_len_next = w_len_next - LenOut;
    end
    unique case (r_state)
      StAccum: begin
        if (w_accept && bus.in_last) begin
          w_state_next = StFlush;
        end
      end
      StFlush: begin
        if (w_emit && w_out_last) begin
          w_state_next = StAccum;
          w_len_next   = '0;
          w_total_next = '0;
        end
      end
      default: w_state_next = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin : p_state
    if (reset) begin
      r_state <= StAccum;
      r_len   <= '0;
      r_total <= '0;
    end else begin
      r_state <= w_state_next;
      r_len   <= w_len_next;
      r_total <= w_total_next;
    end
  end

  always_ff @(posedge clk) begin : p_acc
    r_acc <= w_acc_next;
  end

endmodule

// File: tb/tb_bitpack_stream_ctrl.sv
// Bench for bitpack_stream_ctrl: a bit-queue model checked every cycle plus
// directed scenarios with literal expected words.
module tb_bitpack_stream_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bitpack_stream_if #(.OUT_W(64)) bus ();

  bitpack_stream_ctrl #(.ACC_W(256), .OUT_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the stream as a plain queue of bits, oldest first.
  bit          m_q[$];
  bit          m_flush = 1'b0;
  int unsigned m_total = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          lasts_seen = 0;

  logic [63:0] log_data[$];
  int          log_bits[$];
  bit          log_last[$];
  int          log_cyc[$];

  bit          e_ready, e_valid, e_last;
  int          e_bits, e_n;
  logic [63:0] e_data;

  always @(negedge clk) begin
    cyc++;
    if (bus.in_valid) assert (bus.in_len <= 6'd32) else $error("in_len above 32");
    e_n     = (m_q.size() < 64) ? m_q.size() : 64;
    e_ready = !reset && !m_flush && (m_q.size() <= 224);
    e_valid = !reset && (m_flush || m_q.size() >= 64);
    e_last  = !reset && m_flush && (m_q.size() <= 64);
    e_bits  = reset ? 0 : (m_flush ? e_n : 64);
    e_data  = '0;
    for (int i = 0; i < e_n; i++) e_data[63-i] = m_q[i];

    chk("in_ready", {127'd0, bus.in_ready}, {127'd0, e_ready});
    chk("out_valid", {127'd0, bus.out_valid}, {127'd0, e_valid});
    if (reset) begin
      chk("rst_out_data", {64'd0, bus.out_data}, 128'd0);
      chk("rst_out_bits", {120'd0, bus.out_bits}, 128'd0);
      chk("rst_out_last", {127'd0, bus.out_last}, 128'd0);
      m_q.delete();
      m_flush = 1'b0;
      m_total = 0;
    end else begin
      if (e_valid) begin
        chk("out_data", {64'd0, bus.out_data}, {64'd0, e_data});
        chk("out_bits", {120'd0, bus.out_bits}, 128'(e_bits));
        chk("out_last", {127'd0, bus.out_last}, {127'd0, e_last});
      end
      chk("total_bits", {96'd0, bus.total_bits}, {96'd0, m_total});
      if (e_valid && bus.out_ready) begin
        log_data.push_back(bus.out_data);
        log_bits.push_back(int'(bus.out_bits));
        log_last.push_back(bus.out_last);
        log_cyc.push_back(cyc);
        if (bus.out_last) lasts_seen++;
        for (int i = 0; i < (m_flush ? e_n : 64); i++) void'(m_q.pop_front());
        if (e_last) begin
          m_flush = 1'b0;
          m_total = 0;
        end
      end
      if (bus.in_valid && e_ready) begin
        for (int i = int'(bus.in_len) - 1; i >= 0; i--) m_q.push_back(bus.in_code[i]);
        m_total += 32'(bus.in_len);
        if (bus.in_last) m_flush = 1'b1;
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] code, input logic [5:0] len, input bit last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_len   = len;
    bus.in_last  = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_last(input int target);
    for (int i = 0; i < 300 && lasts_seen < target; i++) idle(1);
    chk("last_word_seen", 128'(lasts_seen >= target), 128'd1);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_bits.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  int acc20_cyc;
  int lasts_before;

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("post_rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("post_rst_total", {96'd0, bus.total_bits}, 128'd0);
    @(posedge clk);
    #1;

    // Byte packing
    clear_log();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'(i + 1), 6'd8, 1'b0);
    idle(2);
    chk("byte_words", 128'(log_data.size()), 128'd1);
    if (log_data.size() >= 1) begin
      chk("byte_data", {64'd0, log_data[0]}, {64'd0, 64'h0102030405060708});
      chk("byte_bits", 128'(log_bits[0]), 128'd64);
      chk("byte_last", 128'(log_last[0]), 128'd0);
      chk("byte_latency", 128'(log_cyc[0]), 128'(last_acc_cyc + 1));
    end

    // Backpressure: fill to 256 bits, then drain
    clear_log();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + 32'(i), 6'd32, 1'b0);
    idle(2);
    chk("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
    chk("bp_hold_data", {64'd0, bus.out_data}, {64'd0, 64'hA0000000A0000001});
    idle(3);
    chk("bp_hold_stable", {64'd0, bus.out_data}, {64'd0, 64'hA0000000A0000001});
    bus.out_ready = 1'b1;
    send(32'hA000_0008, 6'd32, 1'b0);
    send(32'hA000_0009, 6'd32, 1'b1);
    wait_last(1);
    chk("bp_words", 128'(log_data.size()), 128'd5);
    if (log_data.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("bp_order", {64'd0, log_data[k]},
            {64'd0, 32'hA000_0000 + 32'(2 * k), 32'hA000_0000 + 32'(2 * k + 1)});
        chk("bp_last_tag", 128'(log_last[k]), 128'(k == 4));
      end
    end

    // Partial flush with garbage above in_len
    clear_log();
    send(32'hFFFF_FFF5, 6'd3, 1'b0);
    send(32'h0000_123F, 6'd4, 1'b1);
    wait_last(2);
    if (log_data.size() == 1) begin
      chk("partial_data", {64'd0, log_data[0]}, {64'd0, 64'hBE00000000000000});
      chk("partial_bits", 128'(log_bits[0]), 128'd7);
      chk("partial_last", 128'(log_last[0]), 128'd1);
    end else chk("partial_words", 128'(log_data.size()), 128'd1);
    idle(1);
    chk("partial_total_clr", {96'd0, bus.total_bits}, 128'd0);
    chk("partial_back_accum", {127'd0, bus.in_ready}, 128'd1);

    // Exact flush
    clear_log();
    for (int i = 0; i < 8; i++) send(32'h11 + 32'(i), 6'd8, i == 7);
    wait_last(3);
    if (log_data.size() == 1) begin
      chk("exact_data", {64'd0, log_data[0]}, {64'd0, 64'h1112131415161718});
      chk("exact_bits", 128'(log_bits[0]), 128'd64);
      chk("exact_last", 128'(log_last[0]), 128'd1);
    end else chk("exact_words", 128'(log_data.size()), 128'd1);

    // Terminator word from an empty flush
    clear_log();
    send(32'hDEAD_BEEF, 6'd0, 1'b1);
    wait_last(4);
    if (log_data.size() == 1) begin
      chk("term_data", {64'd0, log_data[0]}, 128'd0);
      chk("term_bits", 128'(log_bits[0]), 128'd0);
      chk("term_last", 128'(log_last[0]), 128'd1);
    end else chk("term_words", 128'(log_data.size()), 128'd1);

    // Simultaneous accept and emit at acc_len=64
    clear_log();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h21 + 32'(i), 6'd8, 1'b0);
    idle(1);
    bus.out_ready = 1'b1;
    send(32'hFFFA_BCDE, 6'd20, 1'b0);
    acc20_cyc = last_acc_cyc;
    send(32'h0, 6'd0, 1'b1);
    wait_last(5);
    if (log_data.size() == 2) begin
      chk("simul_word0", {64'd0, log_data[0]}, {64'd0, 64'h2122232425262728});
      chk("simul_same_cycle", 128'(log_cyc[0]), 128'(acc20_cyc));
      chk("simul_word1", {64'd0, log_data[1]}, {64'd0, 64'hABCDE00000000000});
      chk("simul_bits1", 128'(log_bits[1]), 128'd20);
      chk("simul_last1", 128'(log_last[1]), 128'd1);
    end else chk("simul_words", 128'(log_data.size()), 128'd2);

    // Reset during FLUSH discards the residue
    clear_log();
    bus.out_ready = 1'b0;
    send(32'h31, 6'd8, 1'b0);
    send(32'h32, 6'd8, 1'b0);
    send(32'h33, 6'd8, 1'b1);
    idle(2);
    chk("mid_flush_valid", {127'd0, bus.out_valid}, 128'd1);
    lasts_before = lasts_seen;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_kills_valid", {127'd0, bus.out_valid}, 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idle(5);
    chk("rst_no_words", 128'(log_data.size()), 128'd0);
    chk("rst_no_last", 128'(lasts_seen), 128'(lasts_before));
    chk("rst_valid_low", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_total_zero", {96'd0, bus.total_bits}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
